// File: rtl/multi_src_ctrl.sv
// Multi-source capture controller.
// Routes one of N_SRC producer channels into a downstream buffer. Sessions are
// started by start edges and ended by stop edges. A start edge on another channel
// during a session queues that channel as pending. The controller then drains the
// buffer and switches over to the pending channel.
//
// Write handshake: wr_en is a strobe qualified by ~buf_full. A word moves on every
// rising edge of clock where wr_en is high. There is no retry and no back-pressure
// beyond buf_full. In RUN, src_en[sel] equals wr_en, so the producer advances in
// lock-step with each accepted word.
module multi_src_ctrl #(
    parameter  int N_SRC    = 4,
    parameter  int DW       = 16,
    parameter  int DRAIN_TO = 255,
    localparam int SW       = (N_SRC > 2) ? $clog2(N_SRC) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_SRC-1:0]    start,
    input  logic                stop,
    input  logic [N_SRC*DW-1:0] src_data,
    input  logic                buf_full,
    input  logic                buf_empty,
    input  logic                rd_valid,
    output logic [N_SRC-1:0]    src_en,
    output logic                wr_en,
    output logic [DW-1:0]       wr_data,
    output logic [SW-1:0]       sel,
    output logic [3:0]          state_led,
    output logic [15:0]         word_cnt,
    output logic                drain_to
);

    // One-hot encoding doubles as the state_led debug view.
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_RUN   = 4'b0010,
        S_WAIT  = 4'b0100,
        S_DRAIN = 4'b1000
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(DRAIN_TO - 1);

    state_t           state_q, state_d;
    logic [N_SRC-1:0] start_hist_q;
    logic             stop_hist_q;
    logic [SW-1:0]    sel_q, sel_d;
    logic [SW-1:0]    pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [15:0]      word_cnt_q, word_cnt_d;
    logic [15:0]      drain_cnt_q, drain_cnt_d;
    logic             drain_to_q, drain_to_d;

    logic [N_SRC-1:0] start_edge;
    logic             stop_edge;
    logic [N_SRC-1:0] sel_mask;
    logic [N_SRC-1:0] other_edge;
    logic             drain_done;

    // Lowest set bit wins when several channels edge together.
    function automatic logic [SW-1:0] lowest_idx(input logic [N_SRC-1:0] v);
        logic [SW-1:0] idx;
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = SW'(i);
        end
        return idx;
    endfunction

    // Edge detection against last cycle's levels, plus a one-hot mask of the active channel.
    always_comb begin
        start_edge = start & ~start_hist_q;
        stop_edge  = stop & ~stop_hist_q;
        for (int i = 0; i < N_SRC; i++) begin
            sel_mask[i] = (sel_q == SW'(i));
        end
        other_edge = start_edge & ~sel_mask;
        drain_done = buf_empty & ~rd_valid;
    end

    // State and datapath registers. History clears on reset, so a start held through release counts as an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            start_hist_q <= '0;
            stop_hist_q  <= 1'b0;
            sel_q        <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            word_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            drain_to_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_hist_q <= start;
            stop_hist_q  <= stop;
            sel_q        <= sel_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            word_cnt_q   <= word_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            drain_to_q   <= drain_to_d;
        end
    end

    // Next-state logic: session start, flow control, channel switch and drain exit/timeout.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        word_cnt_d  = word_cnt_q + {15'd0, wr_en};
        drain_cnt_d = drain_cnt_q;
        drain_to_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A stop edge in the same cycle does not block the start.
                if (|start_edge) begin
                    sel_d      = lowest_idx(start_edge);
                    word_cnt_d = '0;
                    state_d    = S_RUN;
                end
            end

            S_RUN, S_WAIT: begin
                if (|other_edge) begin
                    pend_d     = lowest_idx(other_edge);
                    pend_vld_d = 1'b1;
                end
                // Stop or a channel switch outranks buf_full flow control.
                if (stop_edge || (|other_edge)) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end else if (state_q == S_RUN && buf_full) begin
                    state_d = S_WAIT;
                end else if (state_q == S_WAIT && !buf_full) begin
                    state_d = S_RUN;
                end
            end

            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 16'd1;
                // A stop cancels any queued switch. Otherwise the newest start edge replaces it.
                if (stop_edge) begin
                    pend_vld_d = 1'b0;
                end else if (|other_edge) begin
                    pend_d     = lowest_idx(other_edge);
                    pend_vld_d = 1'b1;
                end
                // A normal exit beats a timeout landing in the same cycle.
                if (drain_done) begin
                    if (pend_vld_d) begin
                        state_d    = S_RUN;
                        sel_d      = pend_d;
                        pend_vld_d = 1'b0;
                        word_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (drain_cnt_q == TO_LAST) begin
                    state_d    = S_IDLE;
                    pend_vld_d = 1'b0;
                    drain_to_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: enables follow ~buf_full combinationally, and data is only steered while in RUN.
    always_comb begin
        src_en  = '0;
        wr_en   = 1'b0;
        wr_data = '0;
        if (state_q == S_RUN) begin
            wr_en  = ~buf_full;
            src_en = sel_mask & {N_SRC{~buf_full}};
            for (int i = 0; i < N_SRC; i++) begin
                if (sel_mask[i]) wr_data = src_data[i*DW +: DW];
            end
        end
    end

    assign sel       = sel_q;
    assign state_led = state_q;
    assign word_cnt  = word_cnt_q;
    assign drain_to  = drain_to_q;

endmodule

// File: tb/tb_multi_src_ctrl.sv
// Directed bench for multi_src_ctrl (N_SRC=4, DW=16, DRAIN_TO=8).
// Inputs change on falling edges. Outputs are sampled 1ns after the falling edge.
module tb_multi_src_ctrl;

    logic        clock;
    logic        reset;
    logic [3:0]  start;
    logic        stop;
    logic [63:0] src_data;
    logic        buf_full;
    logic        buf_empty;
    logic        rd_valid;
    logic [3:0]  src_en;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [1:0]  sel;
    logic [3:0]  state_led;
    logic [15:0] word_cnt;
    logic        drain_to;

    int checks = 0;
    int errors = 0;

    multi_src_ctrl #(.N_SRC(4), .DW(16), .DRAIN_TO(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .src_data  (src_data),
        .buf_full  (buf_full),
        .buf_empty (buf_empty),
        .rd_valid  (rd_valid),
        .src_en    (src_en),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .sel       (sel),
        .state_led (state_led),
        .word_cnt  (word_cnt),
        .drain_to  (drain_to)
    );

    // Clock and watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    // Driver tasks
    task automatic apply_reset();
        @(negedge clock);
        reset     = 1'b1;
        start     = '0;
        stop      = 1'b0;
        buf_full  = 1'b0;
        buf_empty = 1'b0;
        rd_valid  = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Called at a falling edge. Returns one falling edge later with the DUT in RUN on channel ch.
    task automatic begin_session(input int ch);
        start = 4'(1 << ch);
        @(negedge clock);
        start = '0;
    endtask

    // Test tasks
    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        start = '0; stop = 1'b0; buf_full = 1'b0; buf_empty = 1'b0; rd_valid = 1'b0;
        #1;
        checks++;
        if ({state_led, sel, src_en, wr_en, wr_data, word_cnt, drain_to} !==
            {4'b0001, 2'd0, 4'b0000, 1'b0, 16'h0000, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got led=%b sel=%0d en=%b wr=%b data=%h cnt=%0d to=%b required 0001/0/0000/0/0000/0/0",
                     state_led, sel, src_en, wr_en, wr_data, word_cnt, drain_to);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_start_hold();
        @(negedge clock);
        reset = 1'b1;
        start = 4'b0010;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        start = '0;
        #1;
        checks++;
        if ({state_led, sel} !== {4'b0010, 2'd1}) begin
            errors++;
            $display("FAIL start_held_through_reset: got led=%b sel=%0d required 0010/1", state_led, sel);
        end
    endtask

    task automatic test_start();
        apply_reset();
        start = 4'b0100;
        @(negedge clock);
        start = '0;
        #1;
        checks++;
        if ({state_led, sel, src_en, wr_en, wr_data, word_cnt} !==
            {4'b0010, 2'd2, 4'b0100, 1'b1, 16'h00AB, 16'd0}) begin
            errors++;
            $display("FAIL start_ch2: got led=%b sel=%0d en=%b wr=%b data=%h cnt=%0d required 0010/2/0100/1/00ab/0",
                     state_led, sel, src_en, wr_en, wr_data, word_cnt);
        end
        @(negedge clock);
        #1;
        checks++;
        if (word_cnt !== 16'd1) begin
            errors++;
            $display("FAIL first_write_count: got %0d required 1", word_cnt);
        end
    endtask

    task automatic test_wait();
        apply_reset();
        begin_session(2);
        @(negedge clock);
        buf_full = 1'b1;
        #1;
        checks++;
        if ({wr_en, src_en} !== {1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL run_full_gating: got wr=%b en=%b required 0/0000", wr_en, src_en);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            checks++;
            if ({state_led, src_en, wr_en, word_cnt} !== {4'b0100, 4'b0000, 1'b0, 16'd1}) begin
                errors++;
                $display("FAIL wait_frozen[%0d]: got led=%b en=%b wr=%b cnt=%0d required 0100/0000/0/1",
                         i, state_led, src_en, wr_en, word_cnt);
            end
        end
        buf_full = 1'b0;
        @(negedge clock);
        #1;
        checks++;
        if ({state_led, wr_en, src_en, word_cnt} !== {4'b0010, 1'b1, 4'b0100, 16'd1}) begin
            errors++;
            $display("FAIL wait_resume: got led=%b wr=%b en=%b cnt=%0d required 0010/1/0100/1",
                     state_led, wr_en, src_en, word_cnt);
        end
        @(negedge clock);
        #1;
        checks++;
        if (word_cnt !== 16'd2) begin
            errors++;
            $display("FAIL resume_count: got %0d required 2", word_cnt);
        end
    endtask

    task automatic test_stop_full();
        apply_reset();
        begin_session(0);
        stop     = 1'b1;
        buf_full = 1'b1;
        @(negedge clock);
        stop     = 1'b0;
        buf_full = 1'b0;
        #1;
        checks++;
        if ({state_led, src_en, wr_en, wr_data, word_cnt} !== {4'b1000, 4'b0000, 1'b0, 16'h0000, 16'd0}) begin
            errors++;
            $display("FAIL stop_over_full: got led=%b en=%b wr=%b data=%h cnt=%0d required 1000/0000/0/0000/0",
                     state_led, src_en, wr_en, wr_data, word_cnt);
        end
        @(negedge clock);
        buf_empty = 1'b1;
        #1;
        checks++;
        if (state_led !== 4'b1000) begin
            errors++;
            $display("FAIL drain_hold: got led=%b required 1000", state_led);
        end
        @(negedge clock);
        buf_empty = 1'b0;
        #1;
        checks++;
        if ({state_led, drain_to} !== {4'b0001, 1'b0}) begin
            errors++;
            $display("FAIL drain_exit_idle: got led=%b to=%b required 0001/0", state_led, drain_to);
        end
        @(negedge clock);
        #1;
        checks++;
        if ({state_led, drain_to} !== {4'b0001, 1'b0}) begin
            errors++;
            $display("FAIL idle_no_timeout: got led=%b to=%b required 0001/0", state_led, drain_to);
        end
    endtask

    task automatic test_pending();
        apply_reset();
        begin_session(0);
        @(negedge clock);
        start = 4'b1010;
        @(negedge clock);
        start = '0;
        #1;
        checks++;
        if ({state_led, wr_en} !== {4'b1000, 1'b0}) begin
            errors++;
            $display("FAIL switch_to_drain: got led=%b wr=%b required 1000/0", state_led, wr_en);
        end
        @(negedge clock);
        buf_empty = 1'b1;
        @(negedge clock);
        buf_empty = 1'b0;
        #1;
        checks++;
        if ({state_led, sel, word_cnt, src_en, wr_data} !== {4'b0010, 2'd1, 16'd0, 4'b0010, 16'h2222}) begin
            errors++;
            $display("FAIL pending_switch: got led=%b sel=%0d cnt=%0d en=%b data=%h required 0010/1/0/0010/2222",
                     state_led, sel, word_cnt, src_en, wr_data);
        end
        @(negedge clock);
        #1;
        checks++;
        if (word_cnt !== 16'd1) begin
            errors++;
            $display("FAIL pending_count: got %0d required 1", word_cnt);
        end
    endtask

    task automatic test_ignore_self();
        apply_reset();
        begin_session(1);
        @(negedge clock);
        start = 4'b0010;
        @(negedge clock);
        start = '0;
        @(negedge clock);
        #1;
        checks++;
        if ({state_led, sel, word_cnt} !== {4'b0010, 2'd1, 16'd3}) begin
            errors++;
            $display("FAIL self_edge_ignored: got led=%b sel=%0d cnt=%0d required 0010/1/3",
                     state_led, sel, word_cnt);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        begin_session(0);
        @(negedge clock);
        start = 4'b0100;
        @(negedge clock);
        start = '0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            checks++;
            if ({state_led, drain_to} !== {4'b1000, 1'b0}) begin
                errors++;
                $display("FAIL drain_cycle[%0d]: got led=%b to=%b required 1000/0", i, state_led, drain_to);
            end
        end
        @(negedge clock);
        #1;
        checks++;
        if ({state_led, drain_to} !== {4'b0001, 1'b1}) begin
            errors++;
            $display("FAIL timeout_pulse: got led=%b to=%b required 0001/1", state_led, drain_to);
        end
        @(negedge clock);
        #1;
        checks++;
        if (drain_to !== 1'b0) begin
            errors++;
            $display("FAIL timeout_single: got to=%b required 0", drain_to);
        end
        // A pending channel left over from the timeout would turn this drain exit into a RUN.
        begin_session(3);
        stop = 1'b1;
        @(negedge clock);
        stop      = 1'b0;
        buf_empty = 1'b1;
        @(negedge clock);
        buf_empty = 1'b0;
        #1;
        checks++;
        if (state_led !== 4'b0001) begin
            errors++;
            $display("FAIL timeout_clears_pending: got led=%b sel=%0d required led 0001", state_led, sel);
        end
    endtask

    task automatic test_exit_at_timeout();
        apply_reset();
        begin_session(0);
        @(negedge clock);
        start = 4'b0100;
        @(negedge clock);
        start = '0;
        repeat (7) @(negedge clock);
        buf_empty = 1'b1;
        @(negedge clock);
        buf_empty = 1'b0;
        #1;
        checks++;
        if ({state_led, sel, drain_to, word_cnt} !== {4'b0010, 2'd2, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL exit_beats_timeout: got led=%b sel=%0d to=%b cnt=%0d required 0010/2/0/0",
                     state_led, sel, drain_to, word_cnt);
        end
    endtask

    task automatic test_stop_clears();
        apply_reset();
        begin_session(0);
        @(negedge clock);
        start = 4'b0100;
        @(negedge clock);
        start = '0;
        stop  = 1'b1;
        @(negedge clock);
        stop      = 1'b0;
        buf_empty = 1'b1;
        @(negedge clock);
        buf_empty = 1'b0;
        #1;
        checks++;
        if (state_led !== 4'b0001) begin
            errors++;
            $display("FAIL stop_clears_pending: got led=%b sel=%0d required led 0001", state_led, sel);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        begin_session(1);
        repeat (5) @(negedge clock);
        #1;
        checks++;
        if (word_cnt !== 16'd5) begin
            errors++;
            $display("FAIL five_writes: got %0d required 5", word_cnt);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({state_led, sel, src_en, wr_en, wr_data, word_cnt, drain_to} !==
            {4'b0001, 2'd0, 4'b0000, 1'b0, 16'h0000, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_run: got led=%b sel=%0d en=%b wr=%b data=%h cnt=%0d to=%b required 0001/0/0000/0/0000/0/0",
                     state_led, sel, src_en, wr_en, wr_data, word_cnt, drain_to);
        end
        @(negedge clock);
        #1;
        checks++;
        if ({wr_en, word_cnt} !== {1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset_hold: got wr=%b cnt=%0d required 0/0", wr_en, word_cnt);
        end
        reset = 1'b0;
    endtask

    // Sequence and final report
    initial begin
        reset     = 1'b1;
        start     = '0;
        stop      = 1'b0;
        buf_full  = 1'b0;
        buf_empty = 1'b0;
        rd_valid  = 1'b0;
        src_data  = {16'h4444, 16'h00AB, 16'h2222, 16'h1111};

        test_reset();
        test_start_hold();
        test_start();
        test_wait();
        test_stop_full();
        test_pending();
        test_ignore_self();
        test_timeout();
        test_exit_at_timeout();
        test_stop_clears();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
